flop_fifo_rr_arb: RTL and testbench

- Round-robin arbiter that drains NUM_Q flop FIFOs (non-registered output mode: data and valid are combinational from the FIFO head) into one shared downstream valid/ready channel.
- Issues the per-queue pop and captures the popped head into a single registered output stage tagged with the source queue ID.
- Optional watermark priority lets queues past their configured watermark pre-empt normal round-robin order.
- Sits between per-source ingress FIFOs and a single shared consumer, e.g. a PCIe write or DMA engine.

---
 rtl/flop_fifo_rr_arb.sv | 140 ++++++++++++++
 tb/tb_flop_fifo_rr_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flop_fifo_rr_arb.sv
// flop_fifo_rr_arb: round-robin drain of NUM_Q flop FIFOs (combinational
// head outputs) into one registered, queue-tagged valid/ready output stage.
// Optional burst mode is enabled by defining FLOP_FIFO_ARB_BURST_EN.
//
// Handshake: a word moves downstream on a cycle where out_valid & out_ready.
// The output stage may load a new word whenever it is empty or being
// accepted in the same cycle (load = ~out_valid | out_ready). A FIFO head is
// consumed on a cycle where its q_pop bit is 1. q_pop is combinational and
// one-hot or zero. While out_valid=1 and out_ready=0, out_data and out_qid
// hold stable.
module flop_fifo_rr_arb #(
    parameter int NUM_Q = 4,
    parameter int WIDTH = 32,
    parameter int QID_W = $clog2(NUM_Q)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sync_rst_n,
    input  logic                   cfg_wmark_prio_en,
    input  logic [7:0]             cfg_burst_len,
    input  logic [NUM_Q-1:0]       q_valid,
    input  logic [NUM_Q*WIDTH-1:0] q_data,
    input  logic [NUM_Q-1:0]       q_wmark,
    output logic [NUM_Q-1:0]       q_pop,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [QID_W-1:0]       out_qid,
    input  logic                   out_ready
);

    logic [QID_W-1:0] last_grant;
    logic [NUM_Q-1:0] wm_hit;
    logic [NUM_Q-1:0] cand;
    logic [QID_W-1:0] rr_sel;
    logic             rr_found;
    logic [QID_W-1:0] grant_q;
    logic             grant_any;
    logic             load;
    logic             pop;
    logic [WIDTH-1:0] grant_data;

    assign load = ~out_valid | out_ready;

    // Watermarked queues form the candidate set when priority is on and any exist.
    always_comb begin
        wm_hit = q_valid & q_wmark;
        cand   = (cfg_wmark_prio_en && (wm_hit != '0)) ? wm_hit : q_valid;
    end

    // Rotating search for the first candidate after last_grant, wrapping mod NUM_Q.
    always_comb begin
        int idx;
        idx      = 0;
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int off = 1; off <= NUM_Q; off++) begin
            idx = int'(last_grant) + off;
            if (idx >= NUM_Q) begin
                idx = idx - NUM_Q;
            end
            if (!rr_found && cand[idx]) begin
                rr_found = 1'b1;
                rr_sel   = QID_W'(idx);
            end
        end
    end

`ifdef FLOP_FIFO_ARB_BURST_EN
    // burst_cnt holds the number of pops made so far in the current burst
    // (0 only out of reset). A burst keeps the grant on last_grant until it
    // reaches eff_len pops or the queue runs dry; watermarks are ignored
    // while a burst is held.
    logic [7:0] burst_cnt;
    logic [7:0] eff_len;
    logic       hold;

    assign eff_len = (cfg_burst_len == 8'd0) ? 8'd1 : cfg_burst_len;
    assign hold    = (burst_cnt != 8'd0) && (burst_cnt < eff_len) && q_valid[last_grant];

    // Burst continuation overrides the round-robin pick.
    always_comb begin
        grant_q   = hold ? last_grant : rr_sel;
        grant_any = hold | rr_found;
    end

    // Count pops within a burst; any pop that is not a continuation starts a new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= 8'd0;
        end else if (!sync_rst_n) begin
            burst_cnt <= 8'd0;
        end else if (pop) begin
            burst_cnt <= hold ? (burst_cnt + 8'd1) : 8'd1;
        end
    end
`else
    logic unused_burst_len;
    assign unused_burst_len = ^cfg_burst_len;

    // Plain round-robin: the grant is the rotating search result.
    always_comb begin
        grant_q   = rr_sel;
        grant_any = rr_found;
    end
`endif

    // Pop only with room in the output stage, a candidate, and neither reset active.
    always_comb begin
        pop   = load & grant_any & rst_n & sync_rst_n;
        q_pop = '0;
        if (pop) begin
            q_pop[grant_q] = 1'b1;
        end
    end

    assign grant_data = q_data[int'(grant_q)*WIDTH +: WIDTH];

    // Output stage: capture the popped head, drain on accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_qid    <= '0;
            last_grant <= QID_W'(NUM_Q - 1);
        end else if (!sync_rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_qid    <= '0;
            last_grant <= QID_W'(NUM_Q - 1);
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_data   <= grant_data;
            out_qid    <= grant_q;
            last_grant <= grant_q;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flop_fifo_rr_arb.sv
// Directed bench for flop_fifo_rr_arb (NUM_Q=4, WIDTH=32) with a simple
// FIFO model per queue whose head word encodes queue and read index.
module tb_flop_fifo_rr_arb;

    localparam int NUM_Q = 4;
    localparam int WIDTH = 32;
    localparam int QID_W = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   sync_rst_n;
    logic                   cfg_wmark_prio_en;
    logic [7:0]             cfg_burst_len;
    logic [NUM_Q-1:0]       q_valid;
    logic [NUM_Q*WIDTH-1:0] q_data;
    logic [NUM_Q-1:0]       q_wmark;
    logic [NUM_Q-1:0]       q_pop;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [QID_W-1:0]       out_qid;
    logic                   out_ready;

    int n_cmp;
    int n_err;
    int cnt[NUM_Q];
    int rd[NUM_Q];
    int exp_idx[NUM_Q];
    logic [WIDTH-1:0] last_d;
    int               last_q;

    flop_fifo_rr_arb #(.NUM_Q(NUM_Q), .WIDTH(WIDTH), .QID_W(QID_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sync_rst_n        (sync_rst_n),
        .cfg_wmark_prio_en (cfg_wmark_prio_en),
        .cfg_burst_len     (cfg_burst_len),
        .q_valid           (q_valid),
        .q_data            (q_data),
        .q_wmark           (q_wmark),
        .q_pop             (q_pop),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_qid           (out_qid),
        .out_ready         (out_ready)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] mk(int q, int r);
        return {8'hD0, q[7:0], r[15:0]};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_q();
        for (int i = 0; i < NUM_Q; i++) begin
            q_valid[i] = (cnt[i] != 0);
            q_data[i*WIDTH +: WIDTH] = mk(i, rd[i]);
        end
    endtask

    task automatic fill(int q, int n);
        cnt[q] = n;
        drive_q();
        #1;
    endtask

    // One clock: capture pops before the edge, retire them from the FIFO model after it.
    task automatic tick();
        logic [NUM_Q-1:0] pops;
        pops = q_pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_Q; i++) begin
            if (pops[i] && cnt[i] > 0) begin
                cnt[i]--;
                rd[i]++;
            end
        end
        drive_q();
        #1;
    endtask

    task automatic expect_pop(int q);
        chk($sformatf("pop_q%0d", q), 64'(q_pop), 64'(1 << q));
        tick();
        chk("pop_valid", 64'(out_valid), 64'd1);
        chk("pop_qid", 64'(out_qid), 64'(q));
        chk("pop_data", 64'(out_data), 64'(mk(q, exp_idx[q])));
        last_d = mk(q, exp_idx[q]);
        last_q = q;
        exp_idx[q]++;
    endtask

    task automatic expect_hold();
        chk("hold_pop", 64'(q_pop), 64'd0);
        tick();
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_qid", 64'(out_qid), 64'(last_q));
        chk("hold_data", 64'(out_data), 64'(last_d));
    endtask

    task automatic expect_idle();
        chk("idle_pop", 64'(q_pop), 64'd0);
        tick();
        chk("idle_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int seq3[10];
        n_cmp = 0;
        n_err = 0;
        last_d = '0;
        last_q = 0;
        for (int i = 0; i < NUM_Q; i++) begin
            cnt[i] = 0;
            rd[i] = 0;
            exp_idx[i] = 0;
        end
        q_valid = '0;
        q_data = '0;
        q_wmark = '0;
        cfg_wmark_prio_en = 1'b0;
        cfg_burst_len = 8'd0;
        out_ready = 1'b1;
        sync_rst_n = 1'b1;
        rst_n = 1'b0;

        // Reset state, with queues already holding data
        for (int i = 0; i < NUM_Q; i++) cnt[i] = 3;
        drive_q();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_qid", 64'(out_qid), 64'd0);
        chk("rst_pop", 64'(q_pop), 64'd0);
        rst_n = 1'b1;
        #1;

        // Full round-robin: 0,1,2,3 x3 with out_ready held high
        for (int k = 0; k < 12; k++) expect_pop(k % 4);
        expect_idle();

        // Two queues with out_ready toggling: 0,2,0,2 and stable holds
        fill(0, 2);
        fill(2, 2);
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b1;
            #1;
            expect_pop((k % 2) * 2);
            out_ready = 1'b0;
            #1;
            expect_hold();
        end
        out_ready = 1'b1;
        #1;
        expect_idle();

        // Watermark priority: queue 3 pre-empts, then RR resumes at queue 0
        cfg_wmark_prio_en = 1'b1;
        q_wmark = 4'b1000;
        fill(0, 2);
        fill(1, 2);
        fill(2, 2);
        fill(3, 4);
        for (int k = 0; k < 3; k++) expect_pop(3);
        q_wmark = 4'b0000;
        #1;
        seq3 = '{0, 1, 2, 3, 0, 1, 2, 0, 0, 0};
        for (int k = 0; k < 7; k++) expect_pop(seq3[k]);
        expect_idle();
        cfg_wmark_prio_en = 1'b0;

        // Skip an empty queue: last_grant=1, queue 2 empty, queue 3 valid
        fill(1, 1);
        expect_pop(1);
        fill(0, 1);
        fill(3, 1);
        expect_pop(3);
        expect_pop(0);
        expect_idle();

        // Synchronous reset while the stage is stalled
        fill(1, 2);
        fill(2, 2);
        expect_pop(1);
        out_ready = 1'b0;
        #1;
        expect_hold();
        sync_rst_n = 1'b0;
        #1;
        chk("srst_pop_stalled", 64'(q_pop), 64'd0);
        tick();
        chk("srst_valid", 64'(out_valid), 64'd0);
        chk("srst_data", 64'(out_data), 64'd0);
        chk("srst_qid", 64'(out_qid), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("srst_pop_forced", 64'(q_pop), 64'd0);
        tick();
        chk("srst_valid2", 64'(out_valid), 64'd0);
        sync_rst_n = 1'b1;
        fill(0, 1);
        expect_pop(0);
        expect_pop(1);
        expect_pop(2);
        expect_pop(2);
        expect_idle();

        // Asynchronous reset mid-cycle with data in the stage
        out_ready = 1'b0;
        fill(3, 1);
        fill(1, 1);
        expect_pop(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_pop", 64'(q_pop), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        expect_pop(1);
        expect_idle();

`ifdef FLOP_FIFO_ARB_BURST_EN
        // Bursts of up to 3 pops, ending early when a queue runs dry
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg_burst_len = 8'd3;
        fill(0, 5);
        fill(1, 5);
        seq3 = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
        for (int k = 0; k < 10; k++) expect_pop(seq3[k]);
        expect_idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
